// File: rtl/hydra_sram_pkg.sv
// rtl/hydra_sram_pkg.sv - shared types and default widths for the SRAM read-side client
//
// Contents:
//   SRAM_ADDR_WIDTH / SRAM_DATA_WIDTH / SRAM_LEN_WIDTH  default widths
//   addr_t, data_t, len_t                               typedefs at those widths
//   rd_state_e                                          burst reader FSM states
package hydra_sram_pkg;

    localparam int SRAM_ADDR_WIDTH = 14;
    localparam int SRAM_DATA_WIDTH = 16;
    localparam int SRAM_LEN_WIDTH  = 8;

    typedef logic [SRAM_ADDR_WIDTH-1:0] addr_t;
    typedef logic [SRAM_DATA_WIDTH-1:0] data_t;
    typedef logic [SRAM_LEN_WIDTH-1:0]  len_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sram_skid_buf.sv
// rtl/sram_skid_buf.sv - 2-entry FIFO holding SRAM read words with a per-entry last flag
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push              write push_data/push_last (ignored when full unless popping)
//   push_data/last    word and end-of-burst flag to store
//   pop               remove head (ignored when empty)
//   head_data/last    oldest entry; stable until popped
//   full, empty       occupancy flags
module sram_skid_buf #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic                  full,
    output logic                  empty
);

    logic [DATA_WIDTH-1:0] data_q [2];
    logic                  last_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic                  push_en;
    logic                  pop_en;

    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign pop_en    = pop & ~empty;
    // When full, a simultaneous pop frees the head slot, which is exactly the
    // slot wr_ptr points at, so the write lands in the entry being retired.
    assign push_en   = push & (~full | pop_en);
    assign head_data = data_q[rd_ptr_q];
    assign head_last = last_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_en) begin
                data_q[wr_ptr_q] <= push_data;
                last_q[wr_ptr_q] <= push_last;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_en) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_burst_reader.sv
// rtl/sram_burst_reader.sv - burst read client for a 1-cycle-latency SRAM read port
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              burst request handshake
//   req_addr, req_len                first word address, word count (0 = empty burst)
//   sram_rd_en, sram_rd_addr         SRAM read port; data returns on sram_dout next cycle
//   sram_dout                        SRAM read data
//   out_valid/out_ready              output word handshake
//   out_data, out_last               word, final-word flag
//   done                             1-cycle pulse after the last word is taken or on an empty burst
module sram_burst_reader
    import hydra_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int DATA_DEPTH = 2 ** SRAM_ADDR_WIDTH,
    parameter int LEN_WIDTH  = SRAM_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  sram_rd_en,
    output logic [ADDR_WIDTH-1:0] sram_rd_addr,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(DATA_DEPTH - 1);

    rd_state_e             state_q;
    rd_state_e             state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic                  done_q;

    logic                  req_fire;
    logic                  rd_issue;
    logic                  pop;
    logic                  buf_full;
    logic                  buf_empty;
    logic                  head_last;
    logic [DATA_WIDTH-1:0] head_data;
    logic [1:0]            buf_count;
    logic [2:0]            credit_used;

    assign req_fire  = req_valid & req_ready;
    assign pop       = ~buf_empty & out_ready;
    assign buf_count = buf_full ? 2'd2 : (buf_empty ? 2'd0 : 2'd1);

    // Words that will occupy the buffer next cycle if nothing new is issued;
    // issuing only while this is below 2 means the in-flight word always has
    // a free slot when it lands.
    assign credit_used = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_issue    = (state_q == READ) && (remaining_q != '0) && (credit_used < 3'd2);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_fire && (req_len != '0)) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (rd_issue && (remaining_q == LEN_WIDTH'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready  = (state_q == IDLE);
        sram_rd_en = rd_issue;
    end

    // Address/length counters, read-latency tracking and completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            if (req_fire) begin
                addr_q      <= req_addr;
                remaining_q <= req_len;
            end else if (rd_issue) begin
                addr_q      <= (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end
            inflight_q      <= rd_issue;
            inflight_last_q <= rd_issue && (remaining_q == LEN_WIDTH'(1));
            done_q          <= (req_fire && (req_len == '0)) ||
                               ((state_q == DRAIN) && pop && head_last);
        end
    end

    sram_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (sram_dout),
        .push_last (inflight_last_q),
        .pop       (pop),
        .head_data (head_data),
        .head_last (head_last),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign sram_rd_addr = addr_q;
    assign out_valid    = ~buf_empty;
    assign out_data     = head_data;
    // Entries keep their last bit after being popped, so qualify with occupancy.
    assign out_last     = ~buf_empty & head_last;
    assign done         = done_q;

endmodule

// File: tb/tb_sram_burst_reader.sv
// tb/tb_sram_burst_reader.sv - randomized self-checking bench for sram_burst_reader
module tb_sram_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [13:0] req_addr;
    logic [7:0]  req_len;
    logic        sram_rd_en;
    logic [13:0] sram_rd_addr;
    logic [15:0] sram_dout = 16'h0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_burst_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .sram_rd_en   (sram_rd_en),
        .sram_rd_addr (sram_rd_addr),
        .sram_dout    (sram_dout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .done         (done)
    );

    // SRAM stand-in: registered read, contents mem[a] = a ^ 16'hA5A5
    always @(posedge clk) begin
        if (sram_rd_en) sram_dout <= {2'b00, sram_rd_addr} ^ 16'hA5A5;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_at(input int a);
        int w;
        w = a % 16384;
        return w[15:0] ^ 16'hA5A5;
    endfunction

    // ---------------- reference model / scoreboard ----------------
    int          cyc         = 0;
    int          exp_done_at = -1;
    bit          busy        = 0;
    int          issued      = 0;
    int          popped      = 0;
    int          burst_pops  = 0;
    int          acc_cyc     = -10;
    int          acc_len     = 0;
    int          acc_mode    = 0;
    int          first_v     = -1;
    bit          prev_stall  = 0;
    logic [15:0] prev_data   = '0;
    logic [13:0] exp_addr_q[$];
    logic [16:0] exp_word_q[$];
    int          mode        = 0;
    int          pat_i       = 0;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (mode)
                0:       out_ready = 1'b1;
                1:       begin out_ready = ((pat_i % 3) == 0); pat_i++; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        logic [16:0] w;
        logic [13:0] ea;
        #2;
        cyc++;
        if (!rst_n) begin
            check_eq("rst_req_ready", req_ready, 1);
            check_eq("rst_rd_en", sram_rd_en, 0);
            check_eq("rst_rd_addr", sram_rd_addr, 0);
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_out_last", out_last, 0);
            check_eq("rst_out_data", out_data, 0);
            check_eq("rst_done", done, 0);
            exp_addr_q.delete();
            exp_word_q.delete();
            busy = 0; exp_done_at = -1; issued = 0; popped = 0; prev_stall = 0;
        end else begin
            if (cyc == exp_done_at) busy = 0;
            check_eq("done", done, 32'(cyc == exp_done_at));
            check_eq("req_ready", req_ready, 32'(!busy));
            if (busy && cyc == acc_cyc + 1) check_eq("rd_latency", sram_rd_en, 1);
            if (busy && out_valid && first_v < 0) begin
                first_v = cyc;
                check_eq("out_latency", cyc - acc_cyc, 3);
            end
            if (sram_rd_en) begin
                if (exp_addr_q.size() == 0) check_eq("rd_unexpected", 1, 0);
                else begin
                    ea = exp_addr_q.pop_front();
                    check_eq("rd_addr", sram_rd_addr, ea);
                end
                issued++;
            end
            if (prev_stall) begin
                check_eq("stall_valid", out_valid, 1);
                check_eq("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_word_q.size() == 0) check_eq("word_unexpected", 1, 0);
                else begin
                    w = exp_word_q.pop_front();
                    check_eq("out_data", out_data, w[15:0]);
                    check_eq("out_last", out_last, w[16]);
                    if (w[16]) begin
                        exp_done_at = cyc + 1;
                        if (acc_mode == 0) check_eq("throughput", cyc - first_v, acc_len - 1);
                    end
                end
                popped++;
                burst_pops++;
            end
            check_eq("outstanding", 32'((issued - popped) <= 2), 1);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (req_valid && req_ready) begin
                acc_cyc    = cyc;
                acc_len    = int'(req_len);
                acc_mode   = mode;
                first_v    = -1;
                burst_pops = 0;
                if (req_len == 0) exp_done_at = cyc + 1;
                else busy = 1;
                for (int i = 0; i < int'(req_len); i++) begin
                    exp_addr_q.push_back(14'((int'(req_addr) + i) % 16384));
                    exp_word_q.push_back({(i == int'(req_len) - 1), word_at(int'(req_addr) + i)});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_req(input int a, input int l, input bit hold);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 14'(a);
        req_len   = 8'(l);
        #1;
        n = 0;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("accept_timeout", req_ready, 1);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        bit ok;
        ok = 0;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            #3;
            if (!busy && exp_word_q.size() == 0 && exp_done_at < cyc) begin
                ok = 1;
                break;
            end
        end
        check_eq("idle_timeout", ok, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        mode = 0; send_req(14'h0010, 4, 0);   wait_idle();
        mode = 0; send_req(14'h3FFE, 4, 0);   wait_idle();
        mode = 1; pat_i = 0; send_req(14'h0200, 8, 0); wait_idle();
        mode = 0; send_req(14'h0123, 0, 0);   wait_idle();
        mode = 2; send_req(14'h3F80, 0, 0);   wait_idle();
        mode = 0; send_req(14'h3F00, 255, 0); wait_idle();
        mode = 2; send_req(14'h3FA0, 255, 0); wait_idle();

        // abort a burst with reset after a few words
        mode = 0; send_req(14'h0100, 10, 0);
        for (n = 0; n < 100 && burst_pops < 3; n++) begin
            @(negedge clk);
            #3;
        end
        check_eq("abort_wait", 32'(burst_pops >= 3), 1);
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_req(14'h0444, 2, 0); wait_idle();

        // back-to-back: second request held while first is in progress
        mode = 1; pat_i = 0;
        send_req(14'h0050, 5, 1);
        send_req(14'h3FFD, 6, 0);
        wait_idle();

        for (int k = 0; k < 12; k++) begin
            mode = int'($urandom_range(0, 2));
            send_req(int'($urandom_range(0, 16383)), int'($urandom_range(0, 40)), 0);
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
